// File: rtl/bist_pkg.sv
// Shared constants and state encoding for the BIST output-response analyser.
package bist_pkg;
  localparam int MISR_W = 3;
  // Feedback taps of x^3+x+1: the shifted-out bit folds back into bits 1 and 0.
  localparam logic [MISR_W-1:0] MISR_TAPS = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_COMPARE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;
endpackage

// File: rtl/misr_3bit.sv
// 3-bit multiple-input signature register, polynomial x^3+x+1, 2-bit parallel input.
module misr_3bit
  import bist_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [MISR_W-1:0] seed,
  input  logic              en,
  input  logic [1:0]        d,
  output logic [MISR_W-1:0] q
);
  logic [MISR_W-1:0] nxt;

  // n0 = s2^d0, n1 = s0^s2^d1, n2 = s1
  always_comb begin
    nxt = {q[MISR_W-2:0], 1'b0} ^ (q[MISR_W-1] ? MISR_TAPS : '0) ^ {1'b0, d};
  end

  always_ff @(posedge clock) begin
    if (reset)     q <= seed;
    else if (load) q <= seed;
    else if (en)   q <= nxt;
  end
endmodule

// File: rtl/bist_ora_misr.sv
// BIST output-response analyser: compacts PATTERNS CUT responses into a MISR
// and compares the final signature against GOLDEN.
module bist_ora_misr
  import bist_pkg::*;
#(
  parameter int                PATTERNS = 7,
  parameter logic [MISR_W-1:0] SEED     = 3'b000,
  parameter logic [MISR_W-1:0] GOLDEN   = 3'b101
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              resp_valid,
  input  logic [1:0]        resp,
  output logic [MISR_W-1:0] signature,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail
);
  localparam int CNT_W = $clog2(PATTERNS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PATTERNS);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             launch;
  logic             capture;

  assign launch  = start && (state == ST_IDLE || state == ST_DONE);
  // Once cnt reaches PATTERNS further valids are dropped, so the counter cannot wrap.
  assign capture = (state == ST_CAPTURE) && resp_valid && (cnt != CNT_FULL);

  misr_3bit u_misr (
    .clock (clock),
    .reset (reset),
    .load  (launch),
    .seed  (SEED),
    .en    (capture),
    .d     (resp),
    .q     (signature)
  );

  // The last capture sets cnt to PATTERNS; the following edge moves to COMPARE,
  // which lasts one cycle, so done rises two edges after the last capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      pass  <= 1'b0;
      fail  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state <= ST_CAPTURE;
            cnt   <= '0;
            pass  <= 1'b0;
            fail  <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (capture)               cnt   <= cnt + 1'b1;
          else if (cnt == CNT_FULL)  state <= ST_COMPARE;
        end
        ST_COMPARE: begin
          pass  <= (signature == GOLDEN);
          fail  <= (signature != GOLDEN);
          state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_CAPTURE) || (state == ST_COMPARE);
  assign done = (state == ST_DONE);
endmodule

// File: tb/tb_bist_ora_misr.sv
// Directed bench for bist_ora_misr: literal signature traces plus a
// polynomial-arithmetic reference model checked every cycle.
module tb_bist_ora_misr;
  localparam int         PATTERNS = 7;
  localparam logic [2:0] SEED     = 3'b000;
  localparam logic [2:0] GOLDEN   = 3'b101;

  logic       clock = 1'b0;
  logic       reset, start, resp_valid;
  logic [1:0] resp;
  logic [2:0] signature;
  logic       busy, done, pass, fail;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  always #5 clock = ~clock;

  bist_ora_misr #(.PATTERNS(PATTERNS), .SEED(SEED), .GOLDEN(GOLDEN)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .resp_valid (resp_valid),
    .resp       (resp),
    .signature  (signature),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail       (fail)
  );

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Signature as a GF(2) polynomial: multiply by x modulo x^3+x+1, add response.
  function automatic logic [2:0] mstep(input logic [2:0] s, input logic [1:0] r);
    logic [3:0] t;
    t = {s, 1'b0};
    if (t[3]) t = t ^ 4'b1011;
    return t[2:0] ^ {1'b0, r};
  endfunction

  // Reference model: phase 0 idle, 1 capturing, 2 finishing, 3 verdict held.
  int         m_phase = 0;
  int         m_cnt   = 0;
  int         m_wait  = 0;
  logic [2:0] m_sig   = SEED;
  bit         m_pass  = 1'b0;
  bit         m_fail  = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      m_phase <= 0; m_cnt <= 0; m_sig <= SEED; m_pass <= 1'b0; m_fail <= 1'b0;
    end else if (m_phase == 0 || m_phase == 3) begin
      if (start) begin
        m_phase <= 1; m_cnt <= 0; m_sig <= SEED; m_pass <= 1'b0; m_fail <= 1'b0;
      end
    end else if (m_phase == 1) begin
      if (resp_valid && m_cnt < PATTERNS) begin
        m_sig <= mstep(m_sig, resp);
        m_cnt <= m_cnt + 1;
        if (m_cnt + 1 == PATTERNS) begin
          m_phase <= 2;
          m_wait  <= 2;
        end
      end
    end else begin
      if (m_wait == 1) begin
        m_phase <= 3;
        m_pass  <= (m_sig == GOLDEN);
        m_fail  <= (m_sig != GOLDEN);
      end else begin
        m_wait <= m_wait - 1;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("model signature", int'(signature), int'(m_sig));
      check("model busy", int'(busy), int'(m_phase == 1 || m_phase == 2));
      check("model done", int'(done), int'(m_phase == 3));
      check("model pass", int'(pass), int'(m_pass));
      check("model fail", int'(fail), int'(m_fail));
      if (pass && fail) check("pass and fail exclusive", 1, 0);
    end
  end

  logic [1:0] fa_ok  [7];
  logic [2:0] tr_ok  [7];
  logic [1:0] fa_bad [7];
  logic [2:0] tr_bad [7];
  logic [1:0] zr     [7];
  logic [2:0] tr_zr  [7];

  // One full test; gaps inserts an idle cycle (with garbage resp and a stray start)
  // before each capture. skip_start assumes the caller already launched the test.
  task automatic run(input string tag, input logic [1:0] r[7], input logic [2:0] e[7],
                     input bit gaps, input bit skip_start);
    logic [2:0] prev;
    if (!skip_start) begin
      start = 1'b1; tick(); start = 1'b0;
      check({tag, " busy after start"}, int'(busy), 1);
      check({tag, " seed loaded"}, int'(signature), int'(SEED));
    end
    for (int i = 0; i < 7; i++) begin
      prev = (i == 0) ? SEED : e[i-1];
      if (gaps) begin
        resp_valid = 1'b0; resp = 2'b11;
        if (i == 3) start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " gap hold"}, int'(signature), int'(prev));
        check({tag, " gap busy"}, int'(busy), 1);
      end
      resp_valid = 1'b1; resp = r[i];
      tick();
      check($sformatf("%s step %0d", tag, i), int'(signature), int'(e[i]));
    end
    resp_valid = 1'b0; resp = 2'b00;
    check({tag, " done edge+0"}, int'(done), 0);
    tick();
    check({tag, " done edge+1"}, int'(done), 0);
    check({tag, " busy edge+1"}, int'(busy), 1);
    tick();
    check({tag, " done edge+2"}, int'(done), 1);
    check({tag, " busy edge+2"}, int'(busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fa_ok  = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b10};
    tr_ok  = '{3'b001, 3'b011, 3'b111, 3'b111, 3'b111, 3'b110, 3'b101};
    fa_bad = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b00};
    tr_bad = '{3'b001, 3'b011, 3'b111, 3'b111, 3'b111, 3'b110, 3'b111};
    zr     = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    tr_zr  = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};

    reset = 1'b1; start = 1'b0; resp_valid = 1'b0; resp = 2'b00;
    tick(); tick();
    chk_en = 1'b1;
    check("reset signature", int'(signature), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset pass", int'(pass), 0);
    check("reset fail", int'(fail), 0);
    start = 1'b1; resp_valid = 1'b1;
    tick();
    check("reset beats start", int'(busy), 0);
    reset = 1'b0; start = 1'b0; resp_valid = 1'b0;

    // Valid responses in IDLE are ignored.
    resp_valid = 1'b1; resp = 2'b11; tick(); resp_valid = 1'b0;
    check("idle ignores valid", int'(signature), 0);

    run("fault-free", fa_ok, tr_ok, 1'b0, 1'b0);
    check("fault-free pass", int'(pass), 1);
    check("fault-free fail", int'(fail), 0);
    resp_valid = 1'b1; resp = 2'b11; tick(); tick(); resp_valid = 1'b0;
    check("done holds signature", int'(signature), 5);
    check("done holds verdict", int'(pass), 1);
    check("done holds done", int'(done), 1);

    run("cout-sa0", fa_bad, tr_bad, 1'b0, 1'b0);
    check("cout-sa0 signature", int'(signature), 7);
    check("cout-sa0 pass", int'(pass), 0);
    check("cout-sa0 fail", int'(fail), 1);

    run("all-zero", zr, tr_zr, 1'b0, 1'b0);
    check("all-zero fail", int'(fail), 1);
    check("all-zero pass", int'(pass), 0);

    run("gapped", fa_ok, tr_ok, 1'b1, 1'b0);
    check("gapped pass", int'(pass), 1);
    check("gapped fail", int'(fail), 0);

    // Abort after four captures.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      resp_valid = 1'b1; resp = fa_ok[i]; tick();
    end
    resp_valid = 1'b0;
    check("pre-abort signature", int'(signature), 7);
    reset = 1'b1; tick(); reset = 1'b0;
    check("abort signature", int'(signature), 0);
    check("abort done", int'(done), 0);
    check("abort busy", int'(busy), 0);
    check("abort fail", int'(fail), 0);
    tick();
    check("abort no verdict", int'(done), 0);
    run("after-abort", fa_ok, tr_ok, 1'b0, 1'b0);
    check("after-abort pass", int'(pass), 1);

    // Restart from DONE clears the verdict on the next cycle.
    start = 1'b1; tick(); start = 1'b0;
    check("restart done", int'(done), 0);
    check("restart pass", int'(pass), 0);
    check("restart busy", int'(busy), 1);
    check("restart signature", int'(signature), 0);
    run("restart", zr, tr_zr, 1'b0, 1'b1);
    check("restart fail", int'(fail), 1);

    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bist_ora_misr.md
BIST_ORA_MISR -- requirements
Module: bist_ora_misr

Interface
REQ-001 The block SHALL have parameter PATTERNS, default 7, giving the number of CUT responses compacted per test.
REQ-002 The block SHALL have parameter SEED, default 3'b000, giving the initial signature value.
REQ-003 The block SHALL have parameter GOLDEN, default 3'b101, giving the fault-free signature.
REQ-004 The block SHALL have port clock, input, 1, the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, the synchronous active-high reset.
REQ-006 The block SHALL have port start, input, 1, a one-cycle request to begin a new test.
REQ-007 The block SHALL have port resp_valid, input, 1, qualifying resp for the current cycle.
REQ-008 The block SHALL have port resp, input, 2, the CUT response: resp[1]=cout, resp[0]=sum.
REQ-009 The block SHALL have port signature, output, 3, the current MISR contents.
REQ-010 The block SHALL have port busy, output, 1, high in CAPTURE and COMPARE.
REQ-011 The block SHALL have port done, output, 1, high while in DONE.
REQ-012 The block SHALL have ports pass and fail, output, 1 each, holding the verdict while done=1 and low otherwise.

Function
REQ-013 The FSM SHALL have the states IDLE, CAPTURE, COMPARE and DONE.
REQ-014 In IDLE or DONE, start=1 SHALL load signature with SEED, clear the pattern counter, clear pass/fail/done, and enter CAPTURE on the next edge.
REQ-015 In CAPTURE, each edge with resp_valid=1 SHALL update the MISR as: n0=s2^r0; n1=s0^s2^r1; n2=s1 (polynomial x^3+x+1); the counter SHALL then increment.
REQ-016 In CAPTURE, resp_valid=0 SHALL hold both the signature and the counter, with no timeout.
REQ-017 The valid capture taken when the counter equals PATTERNS-1 SHALL be the last one, and the FSM SHALL enter COMPARE.
REQ-018 COMPARE SHALL last exactly one cycle, then register pass=(signature==GOLDEN), fail=~pass and done=1, and enter DONE.
REQ-019 done SHALL therefore rise on the second edge after the edge that captured the last response.
REQ-020 DONE SHALL hold signature, pass, fail and done until start or reset.
REQ-021 start SHALL be ignored in CAPTURE and COMPARE.
REQ-022 resp_valid SHALL be ignored outside CAPTURE.
REQ-023 The pattern counter SHALL be $clog2(PATTERNS+1) bits wide and SHALL never wrap within a test.
REQ-024 pass and fail SHALL never be high simultaneously.

Reset
REQ-025 When reset=1 at an edge, the block SHALL enter IDLE with signature=SEED, counter=0, and busy=done=pass=fail=0.
REQ-026 reset SHALL take priority over start and resp_valid.
REQ-027 A reset during CAPTURE or COMPARE SHALL abort the test without producing a verdict.

Structure
REQ-028 Package bist_pkg SHALL hold the state enum, the MISR width constant (3) and the tap constant.
REQ-029 The MISR update SHALL be a sub-module misr_3bit with ports clock, reset, load, seed, en, d[1:0] and q[2:0].
REQ-030 The FSM, counter and comparator SHALL reside in bist_ora_misr.

Verification
REQ-031 Fault-free FA stream, resp = 01,01,01,10,10,11,10 with valid continuous -> signature steps 001,011,111,111,111,110,101; done, pass=1 and fail=0 two edges after the last capture.
REQ-032 Same stream with the last resp=00 (stuck-at-0 on cout) -> signature=111, fail=1, pass=0.
REQ-033 All-zero stream of 7 captures -> signature stays 000; fail=1.
REQ-034 Fault-free stream with resp_valid=0 gaps inserted -> signature and counter hold during gaps; result identical to REQ-031.
REQ-035 Assert reset after 4 captures -> IDLE next edge, signature=000, done=0; a new start plus the full stream -> pass=1.
REQ-036 start pulsed mid-CAPTURE -> ignored; start pulsed in DONE -> restart with a cleared verdict, done=0 on the next cycle.
